// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - debug read-out engine streaming a register-file index range
//
// Purpose: on start, walks registers first_idx..last_idx (wrapping modulo
// NUM_REGS). For each index it drives the read select, captures the read data,
// and offers the word on a valid/ready stream to a debug sink.
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra word to
// every dump. That word carries the XOR of all register words sent, and it is
// the only word flagged with dump_last.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, abort         begin a dump (ignored while busy); cancel a running dump
//   first_idx, last_idx  inclusive index range, latched on start
//   busy, done           engine active; one-cycle completion pulse
//   rf_sel, rf_data      register-file read select and combinational read data
//   dump_valid/ready     output stream handshake
//   dump_data/idx/last   output word, its register index, final-word marker
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  rf_sel,
    input  logic [DATA_W-1:0] rf_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_idx,
    output logic              dump_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    // cur doubles as the read select; it only changes on entry to FETCH, so
    // rf_sel naturally holds its last value in every other state.
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cur_inc;
    logic             at_last;
    logic             handshake;

    assign rf_sel    = cur;
    assign at_last   = (cur == last_q);
    assign cur_inc   = (cur == IDX_W'(NUM_REGS - 1)) ? '0 : cur + 1'b1;
    // Abort wins over a simultaneous handshake: nothing is advanced.
    assign handshake = dump_valid && dump_ready && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        dump_valid = (state == S_SEND);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        if (state == S_CSUM) begin
            dump_valid = 1'b1;
        end
`endif
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: state_next = S_SEND;
            S_SEND: begin
                if (dump_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    state_next = at_last ? S_CSUM : S_FETCH;
`else
                    state_next = at_last ? S_DONE : S_FETCH;
`endif
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM:  if (dump_ready) state_next = S_DONE;
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            last_q    <= '0;
            dump_data <= '0;
            dump_idx  <= '0;
            dump_last <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur    <= first_idx;
                        last_q <= last_idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    // Snapshot taken here; later writes to the register are not seen.
                    dump_data <= rf_data;
                    dump_idx  <= cur;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    dump_last <= 1'b0;
`else
                    dump_last <= at_last;
`endif
                end
                S_SEND: begin
                    if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum <= csum ^ dump_data;
                        if (at_last) begin
                            // Load the trailer word directly, including the word just taken.
                            dump_data <= csum ^ dump_data;
                            dump_idx  <= last_q;
                            dump_last <= 1'b1;
                        end
`endif
                        if (!at_last) begin
                            cur <= cur_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        busy;
    logic        done;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_last;

    logic [31:0] rf [32];
    assign rf_data = rf[rf_sel];

    always #5 clk = ~clk;

    regfile_dump #(.NUM_REGS(32), .IDX_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx),
        .busy(busy), .done(done), .rf_sel(rf_sel), .rf_data(rf_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         count;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_regs();
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    endtask

    // Runs one dump with dump_ready=1 and checks every word against the bench's
    // register model. hold_start keeps start high (with other indices) the whole
    // time, including the DONE cycle, to prove it is ignored.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int exp_count,
                            input bit hold_start, output logic [31:0] csum_out);
        int          gap;
        logic [4:0]  idx;
        logic [31:0] x;
        x          = '0;
        csum_out   = '0;
        start      = 1'b1;
        first_idx  = f;
        last_idx   = l;
        dump_ready = 1'b1;
        step();
        if (hold_start) begin
            first_idx = f + 5'd3;
            last_idx  = l + 5'd7;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < exp_count; i++) begin
            gap = 0;
            while (!dump_valid && gap < 8) begin
                step();
                gap++;
            end
            check("word_gap", gap, 1);
            idx = f + 5'(i);
            check("word_idx", dump_idx, idx);
            check("word_data", dump_data, rf[idx]);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            check("word_last", dump_last, 0);
`else
            check("word_last", dump_last, (i == exp_count - 1));
`endif
            x ^= rf[idx];
            step();
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        check("csum_valid", dump_valid, 1);
        check("csum_data", dump_data, x);
        check("csum_idx", dump_idx, l);
        check("csum_last", dump_last, 1);
        csum_out = dump_data;
        step();
`endif
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("valid_in_done", dump_valid, 0);
        step();
        start = 1'b0;
        check("done_cleared", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [5];
        logic [31:0] cs;

        vecs[0] = '{5'd0,  5'd31, 32};
        vecs[1] = '{5'd30, 5'd1,  4};
        vecs[2] = '{5'd4,  5'd4,  1};
        vecs[3] = '{5'd31, 5'd0,  2};
        vecs[4] = '{5'd10, 5'd12, 3};

        init_regs();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0; dump_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_last", dump_last, 0);
        check("rst_data", dump_data, 0);
        check("rst_idx", dump_idx, 0);
        check("rst_sel", rf_sel, 0);

        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].first, vecs[v].last, vecs[v].count, 1'b0, cs);
            step();
        end

        // Stalled single word: snapshot and stability while the sink is not ready.
        start = 1'b1; first_idx = 5'd4; last_idx = 5'd4; dump_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        rf[4] = 32'hDEAD;
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", dump_valid, 1);
            check("stall_data", dump_data, 32'h104);
            check("stall_idx", dump_idx, 4);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            check("stall_last", dump_last, 0);
`else
            check("stall_last", dump_last, 1);
`endif
            step();
        end
        dump_ready = 1'b1;
        check("stall_data_rdy", dump_data, 32'h104);
        step();
`ifdef REGFILE_DUMP_CHECKSUM_EN
        check("stall_csum", dump_data, 32'h104);
        step();
`endif
        check("stall_done", done, 1);
        step();
        check("stall_idle", busy, 0);
        init_regs();

        // Abort in the third SEND, with the sink ready in the same cycle.
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; dump_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step(); step();
        check("abort_pre_valid", dump_valid, 1);
        check("abort_pre_idx", dump_idx, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", dump_valid, 0);
        check("abort_busy", busy, 0);
        for (int c = 0; c < 4; c++) begin
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
            step();
        end

        // Reset in the middle of a dump.
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_valid", dump_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_data", dump_data, 0);
        check("mrst_idx", dump_idx, 0);
        check("mrst_sel", rf_sel, 0);
        run_dump(5'd0, 5'd31, 32, 1'b0, cs);
        step();

        // start held high throughout (busy and DONE): must not alter the dump.
        run_dump(5'd0, 5'd3, 4, 1'b1, cs);
        step();
        check("held_start_idle", busy, 0);

`ifdef REGFILE_DUMP_CHECKSUM_EN
        rf[0] = 32'h1; rf[1] = 32'h2; rf[2] = 32'h4; rf[3] = 32'h8;
        run_dump(5'd0, 5'd3, 4, 1'b0, cs);
        check("csum_0xF", cs, 32'hF);
        init_regs();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
